// File: rtl/serpent_lt_pipe.sv
// serpent_lt_pipe
//   Pipelined bidirectional Serpent linear transform with valid/ready
//   handshake and full backpressure. Mode (forward/inverse) travels with
//   each beat, so modes may change beat to beat without bubbles.
//
// Parameters
//   PIPE_STAGES : 1 = whole LT in one register stage,
//                 2 = half A in stage 1, half B in stage 2.
// Ports
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_valid, o_ready  : input handshake
//   i_inv, i_data     : mode (1 = inverse) and {X0,X1,X2,X3}, X0 in [127:96]
//   o_valid, i_ready  : output handshake
//   o_inv, o_data     : mode and transformed word, same packing
module serpent_lt_pipe #(
  parameter int PIPE_STAGES = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_inv,
  input  logic [127:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_inv,
  output logic [127:0] o_data
);

  function automatic logic [31:0] rol(input logic [31:0] x, input int unsigned n);
    rol = (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    ror = (x >> n) | (x << (32 - n));
  endfunction

  // First half of the transform in the selected direction. The inverse
  // half A undoes forward half B, so a split pipeline stays symmetric.
  function automatic logic [127:0] half_a(input logic inv, input logic [127:0] d);
    logic [31:0] x0, x1, x2, x3;
    {x0, x1, x2, x3} = d;
    if (!inv) begin
      x0 = rol(x0, 13);
      x2 = rol(x2, 3);
      x1 = x1 ^ x0 ^ x2;
      x3 = x3 ^ x2 ^ (x0 << 3);
      x1 = rol(x1, 1);
      x3 = rol(x3, 7);
    end else begin
      x2 = ror(x2, 22);
      x0 = ror(x0, 5);
      x2 = x2 ^ x3 ^ (x1 << 7);
      x0 = x0 ^ x1 ^ x3;
      x3 = ror(x3, 7);
      x1 = ror(x1, 1);
    end
    half_a = {x0, x1, x2, x3};
  endfunction

  function automatic logic [127:0] half_b(input logic inv, input logic [127:0] d);
    logic [31:0] x0, x1, x2, x3;
    {x0, x1, x2, x3} = d;
    if (!inv) begin
      x0 = x0 ^ x1 ^ x3;
      x2 = x2 ^ x3 ^ (x1 << 7);
      x0 = rol(x0, 5);
      x2 = rol(x2, 22);
    end else begin
      x3 = x3 ^ x2 ^ (x0 << 3);
      x1 = x1 ^ x0 ^ x2;
      x2 = ror(x2, 3);
      x0 = ror(x0, 13);
    end
    half_b = {x0, x1, x2, x3};
  endfunction

  if (PIPE_STAGES == 1) begin : g_one
    logic         r_vld;
    logic         r_inv;
    logic [127:0] r_data;
    logic         w_rdy;

    assign w_rdy = !r_vld || i_ready;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_vld  <= 1'b0;
        r_inv  <= 1'b0;
        r_data <= '0;
      end else if (w_rdy) begin
        r_vld <= i_valid;
        // Data only moves with a real beat so o_data holds while idle.
        if (i_valid) begin
          r_inv  <= i_inv;
          r_data <= half_b(i_inv, half_a(i_inv, i_data));
        end
      end
    end

    assign o_ready = w_rdy;
    assign o_valid = r_vld;
    assign o_inv   = r_inv;
    assign o_data  = r_data;
  end else if (PIPE_STAGES == 2) begin : g_two
    logic         r_vld1, r_vld2;
    logic         r_inv1, r_inv2;
    logic [127:0] r_data1, r_data2;
    logic         w_rdy1, w_rdy2;

    // Ready ripples back combinationally from the output; no skid buffer.
    assign w_rdy2 = !r_vld2 || i_ready;
    assign w_rdy1 = !r_vld1 || w_rdy2;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_vld1  <= 1'b0;
        r_inv1  <= 1'b0;
        r_data1 <= '0;
        r_vld2  <= 1'b0;
        r_inv2  <= 1'b0;
        r_data2 <= '0;
      end else begin
        if (w_rdy1) begin
          r_vld1 <= i_valid;
          if (i_valid) begin
            r_inv1  <= i_inv;
            r_data1 <= half_a(i_inv, i_data);
          end
        end
        if (w_rdy2) begin
          r_vld2 <= r_vld1;
          // Half B uses the mode captured with the beat, not i_inv.
          if (r_vld1) begin
            r_inv2  <= r_inv1;
            r_data2 <= half_b(r_inv1, r_data1);
          end
        end
      end
    end

    assign o_ready = w_rdy1;
    assign o_valid = r_vld2;
    assign o_inv   = r_inv2;
    assign o_data  = r_data2;
  end else begin : g_bad
    $error("serpent_lt_pipe: PIPE_STAGES must be 1 or 2");
  end

endmodule

// File: tb/tb_serpent_lt_pipe.sv
module tb_serpent_lt_pipe;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         vld   [2];
  logic         rdy_o [2];
  logic         inv_i [2];
  logic [127:0] din   [2];
  logic         vo    [2];
  logic         rdy_i [2];
  logic         invo  [2];
  logic [127:0] dout  [2];

  int errors = 0;
  int checks = 0;
  int cur = 0;
  int cyc = 0;
  int bubbles;
  logic [128:0] src_q[$];
  logic [128:0] exp_q[$];
  logic [128:0] got_q[$];
  int           tq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serpent_lt_pipe #(.PIPE_STAGES(1)) u_p1 (
    .i_clk(clk), .i_rst(rst), .i_valid(vld[0]), .o_ready(rdy_o[0]),
    .i_inv(inv_i[0]), .i_data(din[0]), .o_valid(vo[0]), .i_ready(rdy_i[0]),
    .o_inv(invo[0]), .o_data(dout[0]));

  serpent_lt_pipe #(.PIPE_STAGES(2)) u_p2 (
    .i_clk(clk), .i_rst(rst), .i_valid(vld[1]), .o_ready(rdy_o[1]),
    .i_inv(inv_i[1]), .i_data(din[1]), .o_valid(vo[1]), .i_ready(rdy_i[1]),
    .o_inv(invo[1]), .o_data(dout[1]));

  // Output monitor: a transfer is committed at the next rising edge.
  always @(negedge clk)
    if (!rst && vo[cur] && rdy_i[cur]) begin
      got_q.push_back({invo[cur], dout[cur]});
      tq.push_back(cyc);
    end

  // ---------------- reference model (whole transform on a word array) ----
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] lt_fwd(input logic [127:0] d);
    logic [31:0] x[4];
    for (int i = 0; i < 4; i++) x[i] = d[127-32*i -: 32];
    x[0] = rl(x[0], 13);           x[2] = rl(x[2], 3);
    x[1] ^= x[0] ^ x[2];           x[3] ^= x[2] ^ (x[0] << 3);
    x[1] = rl(x[1], 1);            x[3] = rl(x[3], 7);
    x[0] ^= x[1] ^ x[3];           x[2] ^= x[3] ^ (x[1] << 7);
    x[0] = rl(x[0], 5);            x[2] = rl(x[2], 22);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  function automatic logic [127:0] lt_inv(input logic [127:0] d);
    logic [31:0] x[4];
    for (int i = 0; i < 4; i++) x[i] = d[127-32*i -: 32];
    x[2] = rl(x[2], 32-22);        x[0] = rl(x[0], 32-5);
    x[2] ^= x[3] ^ (x[1] << 7);    x[0] ^= x[1] ^ x[3];
    x[3] = rl(x[3], 32-7);         x[1] = rl(x[1], 32-1);
    x[3] ^= x[2] ^ (x[0] << 3);    x[1] ^= x[0] ^ x[2];
    x[2] = rl(x[2], 32-3);         x[0] = rl(x[0], 32-13);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  function automatic logic [128:0] model(input logic [128:0] b);
    return {b[128], b[128] ? lt_inv(b[127:0]) : lt_fwd(b[127:0])};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive src_q[start..] into DUT u until all expected outputs are seen.
  task automatic stream(input int u, input bit rnd_rdy, input int start);
    int idx = start;
    int guard = 0;
    bubbles = 0;
    while ((idx < src_q.size() || got_q.size() < src_q.size()) && guard < 20000) begin
      @(posedge clk); #1;
      if (idx < src_q.size()) begin
        vld[u] = 1'b1;
        {inv_i[u], din[u]} = src_q[idx];
      end else vld[u] = 1'b0;
      rdy_i[u] = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (vld[u] && rdy_o[u]) idx++;
      else if (vld[u] && rdy_i[u]) bubbles++;
      guard++;
    end
    @(posedge clk); #1;
    vld[u] = 1'b0;
    rdy_i[u] = 1'b1;
    checks++;
    if (guard >= 20000) begin
      errors++;
      $display("FAIL stream_timeout u=%0d got=%0d need=%0d", u, got_q.size(), src_q.size());
    end
  endtask

  task automatic test_reset(input int u);
    cur = u;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (vo[u] !== 1'b0 || invo[u] !== 1'b0 || dout[u] !== 128'h0 || rdy_o[u] !== 1'b1) begin
      errors++;
      $display("FAIL reset_state u=%0d vo=%b inv=%b data=%h rdy=%b need 0/0/0/1",
               u, vo[u], invo[u], dout[u], rdy_o[u]);
    end
  endtask

  // One beat on an empty pipe; checks latency and value.
  task automatic send_one(input int u, input logic m, input logic [127:0] d,
                          input logic [127:0] exp_d, input string nm);
    cur = u;
    @(posedge clk); #1;
    vld[u] = 1'b1; inv_i[u] = m; din[u] = d; rdy_i[u] = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy_o[u] !== 1'b1) begin
      errors++; $display("FAIL %s_ready u=%0d got=%b need=1", nm, u, rdy_o[u]);
    end
    @(posedge clk); #1;   // accept edge; single stage is full after it
    vld[u] = 1'b0;
    for (int k = 1; k < u + 1; k++) begin
      checks++;
      if (vo[u] !== 1'b0) begin
        errors++; $display("FAIL %s_early u=%0d vo=%b need=0", nm, u, vo[u]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (vo[u] !== 1'b1 || invo[u] !== m || dout[u] !== exp_d) begin
      errors++;
      $display("FAIL %s u=%0d vo=%b inv=%b data=%h need vo=1 inv=%b data=%h",
               nm, u, vo[u], invo[u], dout[u], m, exp_d);
    end
    @(posedge clk); #1;
    got_q.delete(); tq.delete();
  endtask

  task automatic test_vectors(input int u);
    send_one(u, 1'b0, 128'h00000000_00000000_00000000_00000001,
             128'h00001000_00000000_20000000_00000080, "fwd_x3");
    send_one(u, 1'b0, 128'h00000001_00000000_00000000_00000000,
             128'h100C0000_00004000_00002800_00800000, "fwd_x0");
    send_one(u, 1'b1, 128'h00001000_00000000_20000000_00000080,
             128'h00000000_00000000_00000000_00000001, "inv_x3");
  endtask

  task automatic test_roundtrip(input int u);
    logic [127:0] xs[$];
    int n = 1000;
    cur = u;
    src_q.delete(); exp_q.delete(); got_q.delete(); tq.delete();
    for (int i = 0; i < n; i++) begin
      xs.push_back(rnd128());
      src_q.push_back({1'b0, xs[i]});
      exp_q.push_back({1'b0, lt_fwd(xs[i])});
    end
    stream(u, 1'b0, 0);
    checks++;
    if (bubbles != 0) begin
      errors++; $display("FAIL fwd_throughput u=%0d bubbles=%0d need=0", u, bubbles);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rt_fwd u=%0d beat=%0d got=%h need=%h", u, i,
                 (i < got_q.size()) ? got_q[i] : 129'h0, exp_q[i]);
      end
    end
    src_q.delete();
    for (int i = 0; i < n; i++)
      src_q.push_back({1'b1, (i < got_q.size()) ? got_q[i][127:0] : 128'h0});
    got_q.delete(); tq.delete();
    stream(u, 1'b0, 0);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== {1'b1, xs[i]}) begin
        errors++;
        $display("FAIL rt_inv u=%0d beat=%0d got=%h need=%h", u, i,
                 (i < got_q.size()) ? got_q[i] : 129'h0, {1'b1, xs[i]});
      end
    end
  endtask

  task automatic test_alternate(input int u);
    int n = 64;
    cur = u;
    src_q.delete(); exp_q.delete(); got_q.delete(); tq.delete();
    for (int i = 0; i < n; i++) begin
      src_q.push_back({i[0], rnd128()});
      exp_q.push_back(model(src_q[i]));
    end
    stream(u, 1'b0, 0);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL alt u=%0d beat=%0d got=%h need=%h", u, i,
                 (i < got_q.size()) ? got_q[i] : 129'h0, exp_q[i]);
      end
    end
    checks++;
    if (tq.size() != n || tq[n-1] - tq[0] != n - 1) begin
      errors++;
      $display("FAIL alt_rate u=%0d outs=%0d span=%0d need %0d/%0d", u, tq.size(),
               (tq.size() > 0) ? tq[tq.size()-1] - tq[0] : -1, n, n - 1);
    end
  endtask

  task automatic test_stall(input int u);
    int n = 12;
    int idx = 0;
    bit have = 1'b0;
    bit moved = 1'b0;
    logic [128:0] held = '0;
    cur = u;
    src_q.delete(); exp_q.delete(); got_q.delete(); tq.delete();
    for (int i = 0; i < n; i++) begin
      src_q.push_back({1'($urandom), rnd128()});
      exp_q.push_back(model(src_q[i]));
    end
    rdy_i[u] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vld[u] = 1'b1;
      {inv_i[u], din[u]} = src_q[idx];
      @(negedge clk);
      if (rdy_o[u]) idx++;
      if (vo[u] && !have) begin have = 1'b1; held = {invo[u], dout[u]}; end
      else if (have && (vo[u] !== 1'b1 || {invo[u], dout[u]} !== held)) moved = 1'b1;
    end
    checks++;
    if (idx != u + 1 || rdy_o[u] !== 1'b0) begin
      errors++;
      $display("FAIL stall_fill u=%0d accepted=%0d rdy=%b need %0d/0", u, idx, rdy_o[u], u + 1);
    end
    checks++;
    if (!have || moved || held !== exp_q[0]) begin
      errors++;
      $display("FAIL stall_hold u=%0d seen=%b moved=%b held=%h need=%h", u, have, moved,
               held, exp_q[0]);
    end
    stream(u, 1'b0, idx);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stall_seq u=%0d beat=%0d got=%h need=%h", u, i,
                 (i < got_q.size()) ? got_q[i] : 129'h0, exp_q[i]);
      end
    end
    checks++;
    if (got_q.size() != n) begin
      errors++; $display("FAIL stall_count u=%0d got=%0d need=%0d", u, got_q.size(), n);
    end
  endtask

  task automatic test_back_to_back(input int u);
    int n = 200;
    cur = u;
    src_q.delete(); exp_q.delete(); got_q.delete(); tq.delete();
    for (int i = 0; i < n; i++) begin
      src_q.push_back({1'($urandom), rnd128()});
      exp_q.push_back(model(src_q[i]));
    end
    stream(u, 1'b1, 0);
    checks++;
    if (got_q.size() != n) begin
      errors++; $display("FAIL bp_count u=%0d got=%0d need=%0d", u, got_q.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_seq u=%0d beat=%0d got=%h need=%h", u, i,
                 (i < got_q.size()) ? got_q[i] : 129'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_flight(input int u);
    cur = u;
    got_q.delete(); tq.delete();
    rdy_i[u] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      vld[u] = 1'b1; inv_i[u] = c[0]; din[u] = rnd128();
    end
    @(posedge clk); #1;
    rst = 1'b1;             // beat still presented here must be dropped
    din[u] = rnd128();
    @(posedge clk); #1;
    rst = 1'b0; vld[u] = 1'b0; rdy_i[u] = 1'b1;
    @(negedge clk);
    checks++;
    if (vo[u] !== 1'b0 || dout[u] !== 128'h0 || invo[u] !== 1'b0 || rdy_o[u] !== 1'b1) begin
      errors++;
      $display("FAIL flight_reset u=%0d vo=%b data=%h inv=%b rdy=%b need 0/0/0/1",
               u, vo[u], dout[u], invo[u], rdy_o[u]);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL flight_stale u=%0d outs=%0d need=0", u, got_q.size());
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      vld[u] = 1'b0; inv_i[u] = 1'b0; din[u] = '0; rdy_i[u] = 1'b1;
    end
    repeat (3) @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      test_reset(u);
      test_vectors(u);
      test_roundtrip(u);
      test_alternate(u);
      test_stall(u);
      test_back_to_back(u);
      test_reset_flight(u);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serpent_lt_pipe.md
# serpent_lt_pipe

Pipelined, bidirectional Serpent linear-transform unit. Forward (encrypt) or inverse (decrypt) mode is selected per beat, and a valid/ready handshake gives full backpressure. Pipeline depth is set by a parameter. The block sits between the S-box layer and the round-key mixer in the round datapath, and replaces the fixed combinational inverse-only transform.

## Interface
- PIPE_STAGES, 1: register stages, legal values 1 or 2. Any other value is a synthesis-time error.
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat this cycle
- i_inv  in  1  0 selects forward LT, 1 selects inverse LT; sampled with the beat
- i_data  in  128  {X0,X1,X2,X3}, X0 = [127:96], X3 = [31:0]
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts output
- o_inv  out  1  mode bit travelling with the beat
- o_data  out  128  transformed word, same packing as i_data

## Operation
- Notation: <<< is rotate-left, >>> is rotate-right, << is a logical shift that drops high bits. All arithmetic is 32-bit.
- Forward, half A:
  - X0<<<13; X2<<<3
  - X1 ^= X0^X2; X3 ^= X2^(X0<<3)
  - X1<<<1; X3<<<7
- Forward, half B:
  - X0 ^= X1^X3; X2 ^= X3^(X1<<7)
  - X0<<<5; X2<<<22
- Inverse, half A:
  - X2>>>22; X0>>>5
  - X2 ^= X3^(X1<<7); X0 ^= X1^X3
  - X3>>>7; X1>>>1
- Inverse, half B:
  - X3 ^= X2^(X0<<3); X1 ^= X0^X2
  - X2>>>3; X0>>>13
- Inverse is the exact inverse of forward: inv(fwd(x)) = x for every x. The rotate for X3 is 7, not 8.
- PIPE_STAGES=1: halves A and B are computed combinationally and captured in one stage register.
- PIPE_STAGES=2: stage 1 registers the half-A result plus the mode bit. Stage 2 applies half B in the mode carried in the register.
- Each stage holds one valid flag, one mode bit and 128 data bits.
- Elastic pipeline:
  - A stage loads when it is empty or its contents leave this cycle.
  - o_ready = !stage1_valid || (downstream of stage 1 takes it this cycle).
  - o_ready is combinational from i_ready through the stages. No skid buffer is required.
- Beats leave in order. Modes may change freely beat to beat, with no bubble.
- Reset values: all valid flags 0, so o_valid=0; o_data=0; o_inv=0.
- o_ready is 1 during the cycle after reset deasserts.
- Reset mid-operation discards all in-flight beats.

## Timing
- Latency is PIPE_STAGES cycles. A beat accepted at edge N (i_valid && o_ready) appears with o_valid=1 after edge N+PIPE_STAGES, when no stall occurs.
- Throughput is one beat per cycle while i_ready=1.
- Stall (o_valid && !i_ready): o_data and o_inv hold stable and o_valid stays 1.
  - Upstream stages fill, then o_ready drops.
  - With PIPE_STAGES=2, a stalled pipeline holds 2 beats.
- Simultaneous output pop and input push on a full pipeline: both occur in the same cycle, with no loss and no duplication.
- i_rst has priority over the handshake. A beat presented in the reset cycle is dropped.
- When o_valid=0, o_data holds its last value. It is not required to be 0 after the first beat.

## Test plan
- Run with PIPE_STAGES=1 and PIPE_STAGES=2.
- Forward, i_data = 128'h00000000_00000000_00000000_00000001 -> o_data = 128'h00001000_00000000_20000000_00000080 after PIPE_STAGES cycles, o_inv=0.
- Forward, i_data = 128'h00000001_00000000_00000000_00000000 -> 128'h100C0000_00004000_00002800_00800000.
- Inverse, i_data = 128'h00001000_00000000_20000000_00000080 -> 128'h...0001, o_inv=1. Then 1000 random x run back to back through fwd then inv, each compared to x.
- Alternating i_inv every beat, with i_valid held high and i_ready=1 -> one output per cycle, each beat matching the model for its own mode, order preserved.
- Stall: i_ready=0 for 5 cycles while streaming.
  - o_ready must fall after PIPE_STAGES accepted beats and o_data must stay stable.
  - On release, the beat sequence must be complete, with no drops or duplicates.
- Reset asserted with 2 beats in flight -> next cycle o_valid=0, o_data=0 and o_ready=1. No stale beat may emerge afterwards.
